// File: rtl/gf2_pkg.sv
// Shared definitions for the streaming GF(2) row-reduction block.
//   state_t  : controller states of gf2_rref_stream
//   col_bit  : maps a logical column index to its bit position in a row
//              (column 0 lives in the MSB of the row vector)
package gf2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FIND,
        SWAP,
        ELIM,
        NEXT,
        CHECK,
        EMIT
    } state_t;

    function automatic int unsigned col_bit(input int unsigned c, input int unsigned max_cols);
        return max_cols - 1 - c;
    endfunction

endpackage

// File: rtl/gf2_row_xor_bank.sv
// Parallel conditional-XOR elimination array (purely combinational).
//   mat_i     : current augmented matrix, one packed row per entry
//   piv_row_i : index of the pivot row
//   col_i     : logical pivot column
//   mat_o     : matrix with the pivot row XORed into every other row that
//               has a 1 in the pivot column; the pivot row itself is kept
module gf2_row_xor_bank
    import gf2_pkg::*;
#(
    parameter int MAX_ROWS = 16,
    parameter int MAX_COLS = 16,
    parameter int ROWS_W   = $clog2(MAX_ROWS + 1),
    parameter int COLS_W   = $clog2(MAX_COLS + 1)
) (
    input  logic [MAX_ROWS-1:0][MAX_COLS-1:0] mat_i,
    input  logic [ROWS_W-1:0]                 piv_row_i,
    input  logic [COLS_W-1:0]                 col_i,
    output logic [MAX_ROWS-1:0][MAX_COLS-1:0] mat_o
);

    localparam int RIDX_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int CIDX_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    logic [MAX_COLS-1:0] piv_row;
    logic [CIDX_W-1:0]   cbit;

    always_comb begin
        piv_row = mat_i[piv_row_i[RIDX_W-1:0]];
        cbit    = CIDX_W'(col_bit(32'(col_i), MAX_COLS));
        mat_o   = mat_i;
        for (int unsigned r = 0; r < MAX_ROWS; r++) begin
            if ((r != 32'(piv_row_i)) && mat_i[r][cbit]) begin
                mat_o[r] = mat_i[r] ^ piv_row;
            end
        end
    end

endmodule

// File: rtl/gf2_rref_stream.sv
// Streaming GF(2) reduction of an augmented matrix [A|B] to RREF.
//   cfg_*      : job configuration (rows, used columns, RHS columns), accepted in IDLE
//   in_*       : input row stream, accepted in LOAD
//   out_*      : reduced row stream, produced in EMIT; out_last marks the final row
//   rank       : number of pivots found
//   pivot_mask : 1 per pivot column, same bit order as rows (column 0 = MSB)
//   consistent : 0 if a zero-coefficient row carries a nonzero RHS
//   busy       : controller not in IDLE
//   abort      : synchronous return to IDLE, wins over any handshake
module gf2_rref_stream
    import gf2_pkg::*;
#(
    parameter int MAX_ROWS = 16,
    parameter int MAX_COLS = 16,
    parameter int MAX_RHS  = 4,
    parameter int ROWS_W   = $clog2(MAX_ROWS + 1),
    parameter int COLS_W   = $clog2(MAX_COLS + 1),
    parameter int RHS_W    = $clog2(MAX_RHS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                abort,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ROWS_W-1:0]   cfg_rows,
    input  logic [COLS_W-1:0]   cfg_cols,
    input  logic [RHS_W-1:0]    cfg_rhs,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_COLS-1:0] in_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MAX_COLS-1:0] out_row,
    output logic                out_last,
    output logic [ROWS_W-1:0]   rank,
    output logic [MAX_COLS-1:0] pivot_mask,
    output logic                consistent,
    output logic                busy
);

    localparam int RIDX_W = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int CIDX_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    typedef logic [MAX_ROWS-1:0][MAX_COLS-1:0] mat_t;

    state_t              state_q, state_d;
    mat_t                aug_q, aug_d;
    mat_t                elim_mat;
    logic [ROWS_W-1:0]   rows_q, rows_d;
    logic [COLS_W-1:0]   ncoef_q, ncoef_d;
    logic [MAX_COLS-1:0] colmask_q, colmask_d;
    logic [MAX_COLS-1:0] rhsmask_q, rhsmask_d;
    logic [ROWS_W-1:0]   cnt_q, cnt_d;
    logic [ROWS_W-1:0]   scan_q, scan_d;
    logic [RIDX_W-1:0]   piv_q, piv_d;
    logic [COLS_W-1:0]   col_q, col_d;
    logic [ROWS_W-1:0]   rank_q, rank_d;
    logic [MAX_COLS-1:0] pmask_q, pmask_d;
    logic                cons_q, cons_d;

    // clamped configuration
    logic [ROWS_W-1:0]   rows_c;
    logic [COLS_W-1:0]   cols_c;
    logic [RHS_W-1:0]    rhs_c;
    logic [COLS_W-1:0]   ncoef_c;
    logic [MAX_COLS-1:0] colmask_c;
    logic [MAX_COLS-1:0] rhsmask_c;

    logic [CIDX_W-1:0]   cbit;
    logic [ROWS_W-1:0]   rows_m1;

    gf2_row_xor_bank #(
        .MAX_ROWS (MAX_ROWS),
        .MAX_COLS (MAX_COLS),
        .ROWS_W   (ROWS_W),
        .COLS_W   (COLS_W)
    ) u_xor_bank (
        .mat_i     (aug_q),
        .piv_row_i (rank_q),
        .col_i     (col_q),
        .mat_o     (elim_mat)
    );

    // Configuration clamp and column masks
    always_comb begin
        rows_c = (32'(cfg_rows) > MAX_ROWS) ? ROWS_W'(MAX_ROWS) : cfg_rows;
        cols_c = (32'(cfg_cols) > MAX_COLS) ? COLS_W'(MAX_COLS) : cfg_cols;
        rhs_c  = (32'(cfg_rhs) > MAX_RHS) ? RHS_W'(MAX_RHS) : cfg_rhs;
        if (32'(rhs_c) > 32'(cols_c)) begin
            rhs_c = RHS_W'(cols_c);
        end
        ncoef_c   = cols_c - COLS_W'(rhs_c);
        colmask_c = '0;
        rhsmask_c = '0;
        for (int unsigned c = 0; c < MAX_COLS; c++) begin
            colmask_c[CIDX_W'(col_bit(c, MAX_COLS))] = (c < 32'(cols_c));
            rhsmask_c[CIDX_W'(col_bit(c, MAX_COLS))] = (c < 32'(cols_c)) && (c >= 32'(ncoef_c));
        end
    end

    // Next-state and outputs
    always_comb begin
        state_d   = state_q;
        aug_d     = aug_q;
        rows_d    = rows_q;
        ncoef_d   = ncoef_q;
        colmask_d = colmask_q;
        rhsmask_d = rhsmask_q;
        cnt_d     = cnt_q;
        scan_d    = scan_q;
        piv_d     = piv_q;
        col_d     = col_q;
        rank_d    = rank_q;
        pmask_d   = pmask_q;
        cons_d    = cons_q;

        cbit    = CIDX_W'(col_bit(32'(col_q), MAX_COLS));
        rows_m1 = rows_q - ROWS_W'(1);

        cfg_ready = (state_q == IDLE);
        in_ready  = (state_q == LOAD);
        busy      = (state_q != IDLE);
        out_valid = (state_q == EMIT) && (rows_q != '0);
        out_row   = out_valid ? aug_q[cnt_q[RIDX_W-1:0]] : '0;
        out_last  = out_valid && (cnt_q == rows_m1);

        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    rows_d    = rows_c;
                    ncoef_d   = ncoef_c;
                    colmask_d = colmask_c;
                    rhsmask_d = rhsmask_c;
                    aug_d     = '0;
                    cnt_d     = '0;
                    col_d     = '0;
                    rank_d    = '0;
                    pmask_d   = '0;
                    cons_d    = 1'b1;
                    state_d   = (rows_c == '0) ? EMIT : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    aug_d[cnt_q[RIDX_W-1:0]] = in_row & colmask_q;
                    cnt_d = cnt_q + ROWS_W'(1);
                    if (cnt_q == rows_m1) begin
                        cnt_d   = '0;
                        scan_d  = '0;
                        // no coefficient columns: nothing to eliminate
                        state_d = (ncoef_q == '0) ? CHECK : FIND;
                    end
                end
            end
            FIND: begin
                if (aug_q[scan_q[RIDX_W-1:0]][cbit]) begin
                    piv_d   = scan_q[RIDX_W-1:0];
                    state_d = (scan_q == rank_q) ? ELIM : SWAP;
                end else if (scan_q == rows_m1) begin
                    state_d = NEXT;
                end else begin
                    scan_d = scan_q + ROWS_W'(1);
                end
            end
            SWAP: begin
                aug_d[rank_q[RIDX_W-1:0]] = aug_q[piv_q];
                aug_d[piv_q]              = aug_q[rank_q[RIDX_W-1:0]];
                state_d                   = ELIM;
            end
            ELIM: begin
                aug_d         = elim_mat;
                pmask_d[cbit] = 1'b1;
                rank_d        = rank_q + ROWS_W'(1);
                state_d       = NEXT;
            end
            NEXT: begin
                col_d = col_q + COLS_W'(1);
                if ((col_d == ncoef_q) || (rank_q == rows_q)) begin
                    state_d = CHECK;
                end else begin
                    scan_d  = rank_q;
                    state_d = FIND;
                end
            end
            CHECK: begin
                for (int unsigned r = 0; r < MAX_ROWS; r++) begin
                    if ((r >= 32'(rank_q)) && (r < 32'(rows_q)) && ((aug_q[r] & rhsmask_q) != '0)) begin
                        cons_d = 1'b0;
                    end
                end
                cnt_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                if (rows_q == '0) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (cnt_q == rows_m1) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + ROWS_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            rank_d  = '0;
            pmask_d = '0;
            cons_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            aug_q     <= '0;
            rows_q    <= '0;
            ncoef_q   <= '0;
            colmask_q <= '0;
            rhsmask_q <= '0;
            cnt_q     <= '0;
            scan_q    <= '0;
            piv_q     <= '0;
            col_q     <= '0;
            rank_q    <= '0;
            pmask_q   <= '0;
            cons_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            aug_q     <= aug_d;
            rows_q    <= rows_d;
            ncoef_q   <= ncoef_d;
            colmask_q <= colmask_d;
            rhsmask_q <= rhsmask_d;
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            piv_q     <= piv_d;
            col_q     <= col_d;
            rank_q    <= rank_d;
            pmask_q   <= pmask_d;
            cons_q    <= cons_d;
        end
    end

    assign rank       = rank_q;
    assign pivot_mask = pmask_q;
    assign consistent = cons_q;

endmodule

// File: tb/tb_gf2_rref_stream.sv
module tb_gf2_rref_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        abort;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_rows;
    logic [4:0]  cfg_cols;
    logic [2:0]  cfg_rhs;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_row;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_row;
    logic        out_last;
    logic [4:0]  rank;
    logic [15:0] pivot_mask;
    logic        consistent;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gf2_rref_stream #(
        .MAX_ROWS (16),
        .MAX_COLS (16),
        .MAX_RHS  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_rows   (cfg_rows),
        .cfg_cols   (cfg_cols),
        .cfg_rhs    (cfg_rhs),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_last   (out_last),
        .rank       (rank),
        .pivot_mask (pivot_mask),
        .consistent (consistent),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timed_out(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: timeout waiting for DUT", tag);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic send_cfg(input logic [4:0] r, input logic [4:0] c, input logic [2:0] h);
        int n = 0;
        cfg_rows  = r;
        cfg_cols  = c;
        cfg_rhs   = h;
        cfg_valid = 1'b1;
        #1;
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cfg_ready) timed_out("cfg_handshake");
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic push_row(input logic [15:0] r);
        int n = 0;
        in_row   = r;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) timed_out("in_handshake");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timed_out(tag);
    endtask

    task automatic get_beat(input string tag, input logic [15:0] exp_row, input logic exp_last,
                            input logic stall);
        wait_out(tag);
        if (stall) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_row"}, 32'(out_row), 32'(exp_row));
        end
        chk({tag, "_row"}, 32'(out_row), 32'(exp_row));
        chk({tag, "_last"}, 32'(out_last), 32'(exp_last));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_rows  = '0;
        cfg_cols  = '0;
        cfg_rhs   = '0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;

        // reset state
        #12;
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rank", 32'(rank), 32'd0);
        chk("rst_pivot_mask", 32'(pivot_mask), 32'd0);
        chk("rst_consistent", 32'(consistent), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // identity 3x3 + RHS: rows unchanged
        send_cfg(5'd3, 5'd4, 3'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cfg_ready", 32'(cfg_ready), 32'd0);
        push_row(16'h9000);
        push_row(16'h5000);
        push_row(16'h3000);
        wait_out("t1_wait");
        chk("t1_rank", 32'(rank), 32'd3);
        chk("t1_pmask", 32'(pivot_mask), 32'h0000_E000);
        chk("t1_cons", 32'(consistent), 32'd1);
        chk("t1_in_ready_emit", 32'(in_ready), 32'd0);
        get_beat("t1_b0", 16'h9000, 1'b0, 1'b0);
        get_beat("t1_b1", 16'h5000, 1'b0, 1'b0);
        get_beat("t1_b2", 16'h3000, 1'b1, 1'b0);
        chk("t1_idle_valid", 32'(out_valid), 32'd0);
        chk("t1_idle_ready", 32'(cfg_ready), 32'd1);
        chk("t1_rank_stable", 32'(rank), 32'd3);

        // swap needed: 0110/1011/0011 -> 1000/0101/0011
        send_cfg(5'd3, 5'd4, 3'd1);
        chk("t2_cleared_rank", 32'(rank), 32'd0);
        chk("t2_cleared_cons", 32'(consistent), 32'd1);
        push_row(16'h6000);
        push_row(16'hB000);
        push_row(16'h3000);
        wait_out("t2_wait");
        chk("t2_rank", 32'(rank), 32'd3);
        chk("t2_pmask", 32'(pivot_mask), 32'h0000_E000);
        chk("t2_cons", 32'(consistent), 32'd1);
        get_beat("t2_b0", 16'h8000, 1'b0, 1'b0);
        get_beat("t2_b1", 16'h5000, 1'b0, 1'b0);
        get_beat("t2_b2", 16'h3000, 1'b1, 1'b0);

        // inconsistent: 1101/1100 -> 1101/0001
        send_cfg(5'd2, 5'd4, 3'd1);
        push_row(16'hD000);
        push_row(16'hC000);
        wait_out("t3_wait");
        chk("t3_rank", 32'(rank), 32'd1);
        chk("t3_pmask", 32'(pivot_mask), 32'h0000_8000);
        chk("t3_cons", 32'(consistent), 32'd0);
        get_beat("t3_b0", 16'hD000, 1'b0, 1'b0);
        get_beat("t3_b1", 16'h1000, 1'b1, 1'b0);

        // free column + 2 RHS, dependent row, unused bits masked, backpressure
        send_cfg(5'd3, 5'd5, 3'd2);
        push_row(16'hD07F);
        push_row(16'h2BFF);
        push_row(16'hF800);
        wait_out("t4_wait");
        chk("t4_rank", 32'(rank), 32'd2);
        chk("t4_pmask", 32'(pivot_mask), 32'h0000_A000);
        chk("t4_cons", 32'(consistent), 32'd1);
        get_beat("t4_b0", 16'hD000, 1'b0, 1'b1);
        get_beat("t4_b1", 16'h2800, 1'b0, 1'b0);
        get_beat("t4_b2", 16'h0000, 1'b1, 1'b1);
        chk("t4_done", 32'(out_valid), 32'd0);

        // zero rows: one EMIT cycle, no beats
        send_cfg(5'd0, 5'd4, 3'd1);
        chk("t5_emit_busy", 32'(busy), 32'd1);
        chk("t5_emit_novalid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t5_idle", 32'(cfg_ready), 32'd1);
        chk("t5_rank", 32'(rank), 32'd0);
        chk("t5_cons", 32'(consistent), 32'd1);

        // rhs == cols: no elimination, nonzero row makes it inconsistent
        send_cfg(5'd2, 5'd2, 3'd2);
        push_row(16'h4000);
        push_row(16'h0000);
        wait_out("t6_wait");
        chk("t6_rank", 32'(rank), 32'd0);
        chk("t6_pmask", 32'(pivot_mask), 32'd0);
        chk("t6_cons", 32'(consistent), 32'd0);
        get_beat("t6_b0", 16'h4000, 1'b0, 1'b0);
        get_beat("t6_b1", 16'h0000, 1'b1, 1'b0);

        // rhs == 0: always consistent
        send_cfg(5'd1, 5'd3, 3'd0);
        push_row(16'h0000);
        wait_out("t7_wait");
        chk("t7_rank", 32'(rank), 32'd0);
        chk("t7_cons", 32'(consistent), 32'd1);
        get_beat("t7_b0", 16'h0000, 1'b1, 1'b0);

        // abort while in FIND
        send_cfg(5'd3, 5'd4, 3'd1);
        push_row(16'h9000);
        push_row(16'h5000);
        push_row(16'h3000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_out_valid", 32'(out_valid), 32'd0);
        chk("ab_rank", 32'(rank), 32'd0);
        chk("ab_pmask", 32'(pivot_mask), 32'd0);

        // asynchronous reset in the middle of EMIT
        send_cfg(5'd2, 5'd4, 3'd1);
        push_row(16'hD000);
        push_row(16'hC000);
        get_beat("rs_b0", 16'hD000, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rs_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_rank", 32'(rank), 32'd0);
        chk("rs_pmask", 32'(pivot_mask), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fresh job after reset
        send_cfg(5'd3, 5'd4, 3'd1);
        push_row(16'h6000);
        push_row(16'hB000);
        push_row(16'h3000);
        wait_out("nj_wait");
        chk("nj_rank", 32'(rank), 32'd3);
        chk("nj_cons", 32'(consistent), 32'd1);
        get_beat("nj_b0", 16'h8000, 1'b0, 1'b1);
        get_beat("nj_b1", 16'h5000, 1'b0, 1'b0);
        get_beat("nj_b2", 16'h3000, 1'b1, 1'b1);
        chk("nj_idle", 32'(cfg_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
